// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-ported register file: read ports,
// two write ports, the scoreboard claim port and status outputs.
interface register_file_mp_if #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_READ  = 2
) ();

  logic [NUM_READ*ADDR_W-1:0]    ra;
  logic [NUM_READ*WORD_SIZE-1:0] rdata;
  logic [NUM_READ-1:0]           rbusy;

  logic                 we0;
  logic [ADDR_W-1:0]    wa0;
  logic [WORD_SIZE-1:0] wd0;
  logic                 we1;
  logic [ADDR_W-1:0]    wa1;
  logic [WORD_SIZE-1:0] wd1;

  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;

  logic [NUM_REGS-1:0] busy;
  logic                wr_conflict;

  modport master (
    output ra,
    output we0, wa0, wd0,
    output we1, wa1, wd1,
    output claim_en, claim_addr,
    input  rdata, rbusy,
    input  busy, wr_conflict
  );

  modport slave (
    input  ra,
    input  we0, wa0, wd0,
    input  we1, wa1, wd1,
    input  claim_en, claim_addr,
    output rdata, rbusy,
    output busy, wr_conflict
  );

endinterface

// File: rtl/register_file_mp.sv
// Multi-ported GPR file with prioritised dual write, optional bypass,
// optional hardwired x0 and a per-register busy scoreboard.
module register_file_mp #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_READ  = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;
  logic                 conflict_q;
  logic                 conflict_d;

  logic wv0;
  logic wv1;
  logic cv;

  logic [NUM_READ*WORD_SIZE-1:0] rdata;
  logic [NUM_READ-1:0]           rbusy;

  function automatic logic addr_ok(
    input logic [ADDR_W-1:0] a
  );
    logic in_range;
    logic is_zero;
    in_range = 32'(a) < NUM_REGS;
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  always_comb begin
    wv0 = bus.we0 && addr_ok(bus.wa0);
    wv1 = bus.we1 && addr_ok(bus.wa1);
    cv  = bus.claim_en && addr_ok(bus.claim_addr);
  end

  always_comb begin
    conflict_d = wv0 && wv1 && (bus.wa0 == bus.wa1);
  end

  // Claims are applied last: a new producer outranks retiring writebacks.
  always_comb begin
    busy_d = busy_q;
    if (wv0) begin
      busy_d[bus.wa0] = 1'b0;
    end
    if (wv1) begin
      busy_d[bus.wa1] = 1'b0;
    end
    if (cv) begin
      busy_d[bus.claim_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wv0) begin
        regs_q[bus.wa0] <= bus.wd0;
      end
      if (wv1) begin
        regs_q[bus.wa1] <= bus.wd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_W-1:0]    addr;
    logic                 hit0;
    logic                 hit1;
    logic [WORD_SIZE-1:0] data;
    logic                 bsy;

    assign addr = bus.ra[g*ADDR_W +: ADDR_W];

    always_comb begin
      hit0 = (BYPASS != 0) && wv0 && (bus.wa0 == addr);
      hit1 = (BYPASS != 0) && wv1 && (bus.wa1 == addr);
    end

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (addr_ok(addr)) begin
        if (hit1) begin
          data = bus.wd1;
        end else if (hit0) begin
          data = bus.wd0;
        end else begin
          data = regs_q[addr];
        end
        bsy = busy_q[addr] && !(hit0 || hit1);
      end
    end

    assign rdata[g*WORD_SIZE +: WORD_SIZE] = data;
    assign rbusy[g] = bsy;
  end

  assign bus.rdata       = rdata;
  assign bus.rbusy       = rbusy;
  assign bus.busy        = busy_q;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default config (bypass, 32 regs) and a
// 24-register, no-bypass config for range and async reset behaviour.
module tb_register_file_mp;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  register_file_mp_if #(
    .WORD_SIZE(W), .NUM_REGS(32), .ADDR_W(AW), .NUM_READ(NR)
  ) bus_a ();

  register_file_mp_if #(
    .WORD_SIZE(W), .NUM_REGS(24), .ADDR_W(AW), .NUM_READ(NR)
  ) bus_b ();

  register_file_mp #(
    .WORD_SIZE(W), .NUM_REGS(32), .ADDR_W(AW), .NUM_READ(NR),
    .ZERO_REG(1), .BYPASS(1)
  ) u_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
  );

  register_file_mp #(
    .WORD_SIZE(W), .NUM_REGS(24), .ADDR_W(AW), .NUM_READ(NR),
    .ZERO_REG(1), .BYPASS(0)
  ) u_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [W-1:0]  wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [W-1:0]  wd1;
    logic          cen;
    logic [AW-1:0] ca;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [W-1:0]  rd0;
    logic [W-1:0]  rd1;
    logic [1:0]    rb;
    logic          conf;
    logic [31:0]   bz;
  } vec_t;

  typedef struct {
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    logic [1:0]   rb;
    logic         conf;
    logic [31:0]  bz;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(
    input int we0, input int wa0, input logic [31:0] wd0,
    input int we1, input int wa1, input logic [31:0] wd1,
    input int cen, input int ca, input int ra0, input int ra1,
    input logic [31:0] rd0, input logic [31:0] rd1,
    input int rb, input int conf, input logic [31:0] bz
  );
    vec_t v;
    v.we0  = 1'(we0);
    v.wa0  = AW'(wa0);
    v.wd0  = wd0;
    v.we1  = 1'(we1);
    v.wa1  = AW'(wa1);
    v.wd1  = wd1;
    v.cen  = 1'(cen);
    v.ca   = AW'(ca);
    v.ra0  = AW'(ra0);
    v.ra1  = AW'(ra1);
    v.rd0  = rd0;
    v.rd1  = rd1;
    v.rb   = 2'(rb);
    v.conf = 1'(conf);
    v.bz   = bz;
    tbl.push_back(v);
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.we0        = v.we0;
    bus_a.wa0        = v.wa0;
    bus_a.wd0        = v.wd0;
    bus_a.we1        = v.we1;
    bus_a.wa1        = v.wa1;
    bus_a.wd1        = v.wd1;
    bus_a.claim_en   = v.cen;
    bus_a.claim_addr = v.ca;
    bus_a.ra         = {v.ra1, v.ra0};
  endtask

  task automatic idle_a();
    bus_a.we0 = 0; bus_a.wa0 = '0; bus_a.wd0 = '0;
    bus_a.we1 = 0; bus_a.wa1 = '0; bus_a.wd1 = '0;
    bus_a.claim_en = 0; bus_a.claim_addr = '0;
    bus_a.ra = '0;
  endtask

  task automatic idle_b();
    bus_b.we0 = 0; bus_b.wa0 = '0; bus_b.wd0 = '0;
    bus_b.we1 = 0; bus_b.wa1 = '0; bus_b.wd1 = '0;
    bus_b.claim_en = 0; bus_b.claim_addr = '0;
    bus_b.ra = '0;
  endtask

  initial begin
    // we0 wa0 wd0  we1 wa1 wd1  cen ca  ra0 ra1 | rd0 rd1 rb conf busy
    add(1, 3, 'hFFFF_FFFF, 0, 0, 0, 0, 0, 3, 4,
        'hFFFF_FFFF, 0, 0, 0, 0);
    add(1, 5, 'h1234_5678, 0, 0, 0, 0, 0, 5, 3,
        'h1234_5678, 'hFFFF_FFFF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 5, 3,
        'h1234_5678, 'hFFFF_FFFF, 0, 0, 0);
    add(0, 0, 0, 1, 0, 'hDEAD_BEEF, 1, 0, 0, 5,
        0, 'h1234_5678, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0);
    add(1, 7, 'hAAAA_AAAA, 1, 7, 'h5555_5555, 0, 0, 7, 6,
        'h5555_5555, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 6,
        'h5555_5555, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 6,
        'h5555_5555, 0, 0, 0, 0);
    add(1, 10, 'h0A0A, 1, 11, 'h0B0B, 0, 0, 10, 11,
        'h0A0A, 'h0B0B, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 10, 11,
        'h0A0A, 'h0B0B, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 9, 9, 9,
        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 9, 9,
        0, 0, 3, 0, 'h200);
    add(1, 9, 'h99, 0, 0, 0, 1, 9, 9, 2,
        'h99, 0, 0, 0, 'h200);
    add(0, 0, 0, 0, 0, 0, 0, 0, 9, 2,
        'h99, 0, 1, 0, 'h200);
    add(1, 9, 'h1999, 0, 0, 0, 0, 0, 9, 2,
        'h1999, 0, 0, 0, 'h200);
    add(0, 0, 0, 0, 0, 0, 0, 0, 9, 2,
        'h1999, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 4, 4, 0,
        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 4, 4, 0,
        0, 0, 1, 0, 'h10);
    add(0, 0, 0, 1, 4, 'h44, 0, 0, 4, 4,
        'h44, 'h44, 0, 0, 'h10);
    add(0, 0, 0, 1, 12, 'hC, 1, 12, 0, 12,
        0, 'hC, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 12, 12,
        'hC, 'hC, 3, 0, 'h1000);

    // reset held with a write pending on both instances
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle_a();
    idle_b();
    bus_a.we0 = 1; bus_a.wa0 = 3; bus_a.wd0 = 'hFFFF_FFFF;
    bus_a.ra  = {5'd0, 5'd4};
    bus_b.we0 = 1; bus_b.wa0 = 3; bus_b.wd0 = 'hFFFF_FFFF;
    bus_b.ra  = {5'd0, 5'd3};
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_a_rd0", bus_a.rdata[31:0], 0);
    chk("rst_a_rd1", bus_a.rdata[63:32], 0);
    chk("rst_a_busy", bus_a.busy, 0);
    chk("rst_a_conf", 32'(bus_a.wr_conflict), 0);
    chk("rst_b_rd3", bus_b.rdata[31:0], 0);
    chk("rst_b_busy", 32'(bus_b.busy), 0);

    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle_a();
    #1;
    chk("rel_b_rd3", bus_b.rdata[31:0], 0);
    @(negedge clk);
    #1;
    chk("edge_b_rd3", bus_b.rdata[31:0], 'hFFFF_FFFF);
    idle_b();

    foreach (tbl[i]) begin
      exp_t e;
      exp_t got;
      @(negedge clk);
      drive_a(tbl[i]);
      e.rd0  = tbl[i].rd0;
      e.rd1  = tbl[i].rd1;
      e.rb   = tbl[i].rb;
      e.conf = tbl[i].conf;
      e.bz   = tbl[i].bz;
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      chk($sformatf("v%0d_rd0", i), bus_a.rdata[31:0], got.rd0);
      chk($sformatf("v%0d_rd1", i), bus_a.rdata[63:32], got.rd1);
      chk($sformatf("v%0d_rbusy", i), 32'(bus_a.rbusy), 32'(got.rb));
      chk($sformatf("v%0d_conf", i), 32'(bus_a.wr_conflict),
          32'(got.conf));
      chk($sformatf("v%0d_busy", i), bus_a.busy, got.bz);
    end
    @(negedge clk);
    idle_a();

    // no bypass: write visible only after the edge
    bus_b.we0 = 1; bus_b.wa0 = 5; bus_b.wd0 = 'h1234_5678;
    bus_b.ra  = {5'd0, 5'd5};
    #1;
    chk("nobyp_same", bus_b.rdata[31:0], 0);
    @(negedge clk);
    idle_b();
    bus_b.ra = {5'd0, 5'd5};
    #1;
    chk("nobyp_next", bus_b.rdata[31:0], 'h1234_5678);

    // out-of-range write and claim are dropped
    @(negedge clk);
    bus_b.we0 = 1; bus_b.wa0 = 30; bus_b.wd0 = 'h0BAD;
    bus_b.claim_en = 1; bus_b.claim_addr = 30;
    bus_b.ra = {5'd14, 5'd30};
    #1;
    chk("oor_rd_same", bus_b.rdata[31:0], 0);
    chk("oor_rbusy", 32'(bus_b.rbusy), 0);
    @(negedge clk);
    idle_b();
    bus_b.ra = {5'd14, 5'd30};
    #1;
    chk("oor_rd_next", bus_b.rdata[31:0], 0);
    chk("oor_alias", bus_b.rdata[63:32], 0);
    chk("oor_busy", 32'(bus_b.busy), 0);

    // claims then asynchronous reset mid-cycle
    @(negedge clk);
    bus_b.claim_en = 1; bus_b.claim_addr = 4;
    @(negedge clk);
    bus_b.claim_addr = 12;
    @(negedge clk);
    idle_b();
    bus_b.ra = {5'd12, 5'd5};
    #1;
    chk("clm_busy", 32'(bus_b.busy), 'h1010);
    chk("clm_rbusy", 32'(bus_b.rbusy), 2);
    chk("clm_rd5", bus_b.rdata[31:0], 'h1234_5678);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_busy", 32'(bus_b.busy), 0);
    chk("arst_rbusy", 32'(bus_b.rbusy), 0);
    chk("arst_rd5", bus_b.rdata[31:0], 0);
    @(negedge clk);
    rst_b = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Multi-ported, parametrised general-purpose register file for the next-generation pipelined core. It provides NUM_READ combinational read ports and two prioritised write ports: port 0 for ALU writeback and port 1 for load/late writeback. Optional same-cycle write-to-read bypass and an optional hardwired zero register are included. A per-register busy scoreboard lets the issue stage claim destination registers and detect RAW hazards until writeback clears them.

Parameters:
WORD_SIZE, 32, data width in bits
NUM_REGS, 32, number of architectural registers (2..256)
ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
ra  input  NUM_READ*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rdata  output  NUM_READ*WORD_SIZE  packed read data, combinational
rbusy  output  NUM_READ  per-port busy flag for the addressed register, combinational
we0  input  1  write enable, port 0
wa0  input  ADDR_W  write address, port 0
wd0  input  WORD_SIZE  write data, port 0
we1  input  1  write enable, port 1 (higher priority)
wa1  input  ADDR_W  write address, port 1
wd1  input  WORD_SIZE  write data, port 1
claim_en  input  1  mark register claim_addr busy
claim_addr  input  ADDR_W  register being claimed
busy  output  NUM_REGS  registered scoreboard vector
wr_conflict  output  1  registered pulse: both ports wrote the same valid address last cycle

Behaviour:
- Reset is asynchronous and active-low: rst=0 immediately clears all registers, busy, and wr_conflict. Reset mid-operation discards pending claims.
- A write address is valid when its enable is 1, the address is < NUM_REGS, and the address is not 0 when ZERO_REG=1. Invalid writes are silently dropped.
- Writes commit on the rising edge of clk, so data is visible on rdata in the next cycle (or in the same cycle when BYPASS=1).
- Dual write to the same valid address: wd1 is stored, wd0 is discarded, and wr_conflict=1 for exactly one cycle after that edge. Dual writes to different addresses both commit.
- Read data for each port i:
  - Out-of-range address, or address 0 with ZERO_REG=1: rdata=0 and rbusy=0.
  - BYPASS=1 and a valid write to ra[i] in the current cycle: rdata is that write's data, using port-1 priority.
  - Otherwise: rdata is the stored value.
- rbusy[i] is busy_q[ra[i]]. With BYPASS=1, it is forced to 0 when a valid write targets ra[i] in the same cycle.
- Scoreboard update at each clock edge:
  - A valid write clears busy[wa].
  - A valid claim_en sets busy[claim_addr]. Claims follow the same range and zero-register rules as writes.
  - If a claim and a write hit the same register in the same cycle, the claim wins and busy remains 1 (a new producer has taken the register).
  - A claim on an already-busy register is legal; it remains 1.
  - Claims do not affect rbusy until the next cycle.
- busy[0]=0 permanently when ZERO_REG=1. busy bits at index >= NUM_REGS do not exist.
- No internal FSM. State is the register array, the busy vector, and the wr_conflict flop.
- Implementation is behavioural RTL: a for-loop reset, generate loops over read ports, and priority muxes for bypass.

Test Plan:
- Reset: hold rst=0 with we0=1, wa0=3, wd0=0xFFFF_FFFF, then release -> all reads return 0, busy=0, wr_conflict=0; reg3 is written only after the first edge with rst=1.
- Write/read with bypass: we0=1, wa0=5, wd0=0x1234_5678, ra port0=5 in the same cycle -> rdata0=0x1234_5678 immediately (BYPASS=1). With BYPASS=0, rdata0 shows the old value (0) and changes after the edge.
- Zero register: we1=1, wa1=0, wd1=0xDEAD_BEEF, plus claim_en=1, claim_addr=0 -> rdata for ra=0 stays 0, and busy[0] and rbusy stay 0.
- Dual-write conflict: we0=we1=1, wa0=wa1=7, wd0=0xAAAA_AAAA, wd1=0x5555_5555 -> reg7=0x5555_5555 after the edge, and wr_conflict=1 for one cycle, then 0.
- Scoreboard: claim reg9, next cycle rbusy=1 for ra=9. Then we0 to 9 with claim_en=1 on 9 in the same cycle -> busy[9] stays 1. Then a write to 9 alone -> busy[9]=0 at the next edge; during that write cycle rbusy=0 with BYPASS=1.
- Range and reset mid-operation: NUM_REGS=24, write to addr 30 -> dropped and read returns 0. Claim regs 4 and 12, then pulse rst=0 mid-cycle -> busy clears immediately, without waiting for a clock edge.
